// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, multi-cycle multiply, DM wait.
// Optional performance counters are enabled with `define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 3,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  id_mul_start,
    input  logic                  exe_DM_read,
    input  logic [REG_ADDR_W-1:0] exe_wr_addr,
    input  logic                  exe_branch_taken,
    input  logic                  dm_req,
    input  logic                  dm_ready,
    output logic                  pc_we,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_exe_stall,
    output logic                  id_exe_flush,
    output logic                  exe_mem_stall,
    output logic                  exe_mem_flush,
    output logic                  mul_busy
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cyc,
    output logic [31:0]           perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, MUL_BUSY, MEM_WAIT} state_t;

    localparam bit             MUL_MULTI = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             lu_hit;
    logic             mem_hold;
    // Bit 0 = IF/ID, bit 1 = ID/EXE, bit 2 = EXE/MEM
    logic [2:0]       stall_raw, flush_raw, stall_out;

    assign mem_hold = dm_req && !dm_ready;
    assign lu_hit   = exe_DM_read && (exe_wr_addr != '0) &&
                      ((id_rs1_used && (id_rs1_addr == exe_wr_addr)) ||
                       (id_rs2_used && (id_rs2_addr == exe_wr_addr)));

    always_ff @(posedge clk) begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pc_we      = 1'b0;
        stall_raw  = 3'b000;
        flush_raw  = 3'b000;
        mul_busy   = 1'b0;
        if (rst) begin
            state_next = RUN;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                RUN: begin
                    pc_we = 1'b1;
                    if (mem_hold) begin
                        pc_we      = 1'b0;
                        stall_raw  = 3'b111;
                        state_next = MEM_WAIT;
                    end else if (exe_branch_taken) begin
                        flush_raw = 3'b011;
                    end else if (lu_hit) begin
                        pc_we        = 1'b0;
                        stall_raw[0] = 1'b1;
                        flush_raw[1] = 1'b1;
                    end else if (id_mul_start && MUL_MULTI) begin
                        cnt_next   = MUL_LOAD;
                        state_next = MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    mul_busy  = 1'b1;
                    stall_raw = 3'b011;
                    // A pending DM access keeps the MEM instruction in place instead of bubbling it
                    if (mem_hold) stall_raw[2] = 1'b1;
                    else          flush_raw[2] = 1'b1;
                    cnt_next = (cnt_reg != '0) ? cnt_reg - CNT_ONE : '0;
                    if (cnt_reg <= CNT_ONE)
                        state_next = mem_hold ? MEM_WAIT : RUN;
                end
                MEM_WAIT: begin
                    if (!dm_ready) begin
                        stall_raw = 3'b111;
                    end else begin
                        pc_we      = 1'b1;
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // Flush overrides stall on each pipeline register
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_arb
            assign stall_out[gi] = stall_raw[gi] & ~flush_raw[gi];
        end
    endgenerate

    assign if_id_stall   = stall_out[0];
    assign id_exe_stall  = stall_out[1];
    assign exe_mem_stall = stall_out[2];
    assign if_id_flush   = flush_raw[0];
    assign id_exe_flush  = flush_raw[1];
    assign exe_mem_flush = flush_raw[2];

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_reg, perf_flush_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (!pc_we && (perf_stall_reg != 32'hFFFF_FFFF))
                perf_stall_reg <= perf_stall_reg + 32'd1;
            if (if_id_flush && (perf_flush_reg != 32'hFFFF_FFFF))
                perf_flush_reg <= perf_flush_reg + 32'd1;
        end
    end

    assign perf_stall_cyc = perf_stall_reg;
    assign perf_flush_cnt = perf_flush_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a MUL_LAT=3 instance and a MUL_LAT=1 instance share the stimulus.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic       mul_start;
        logic       dm_read;
        logic [4:0] wr_addr;
        logic       br;
        logic       dm_req;
        logic       dm_ready;
    } in_t;

    // Expected bits: {pc_we, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush, exe_mem_stall, exe_mem_flush, mul_busy}
    typedef struct packed {
        in_t        stim;
        logic [7:0] exp;
    } vec_t;

    localparam logic [7:0] O_IDLE   = 8'b1000_0000;
    localparam logic [7:0] O_LU     = 8'b0100_1000;
    localparam logic [7:0] O_BR     = 8'b1010_1000;
    localparam logic [7:0] O_MEM    = 8'b0101_0100;
    localparam logic [7:0] O_MUL    = 8'b0101_0011;
    localparam logic [7:0] O_MULMEM = 8'b0101_0101;
    localparam logic [7:0] O_RST    = 8'b0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  cur = '0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] o3, o1;
    logic pc_we_a, ifs_a, iff_a, ies_a, ief_a, ems_a, emf_a, mb_a;
    logic pc_we_b, ifs_b, iff_b, ies_b, ief_b, ems_b, emf_b, mb_b;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] ps_a, pf_a, ps_b, pf_b;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MUL_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst),
        .id_rs1_addr(cur.rs1), .id_rs2_addr(cur.rs2),
        .id_rs1_used(cur.rs1_used), .id_rs2_used(cur.rs2_used),
        .id_mul_start(cur.mul_start), .exe_DM_read(cur.dm_read),
        .exe_wr_addr(cur.wr_addr), .exe_branch_taken(cur.br),
        .dm_req(cur.dm_req), .dm_ready(cur.dm_ready),
        .pc_we(pc_we_a), .if_id_stall(ifs_a), .if_id_flush(iff_a),
        .id_exe_stall(ies_a), .id_exe_flush(ief_a),
        .exe_mem_stall(ems_a), .exe_mem_flush(emf_a), .mul_busy(mb_a)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .perf_stall_cyc(ps_a), .perf_flush_cnt(pf_a)
`endif
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MUL_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .id_rs1_addr(cur.rs1), .id_rs2_addr(cur.rs2),
        .id_rs1_used(cur.rs1_used), .id_rs2_used(cur.rs2_used),
        .id_mul_start(cur.mul_start), .exe_DM_read(cur.dm_read),
        .exe_wr_addr(cur.wr_addr), .exe_branch_taken(cur.br),
        .dm_req(cur.dm_req), .dm_ready(cur.dm_ready),
        .pc_we(pc_we_b), .if_id_stall(ifs_b), .if_id_flush(iff_b),
        .id_exe_stall(ies_b), .id_exe_flush(ief_b),
        .exe_mem_stall(ems_b), .exe_mem_flush(emf_b), .mul_busy(mb_b)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .perf_stall_cyc(ps_b), .perf_flush_cnt(pf_b)
`endif
    );

    assign o3 = {pc_we_a, ifs_a, iff_a, ies_a, ief_a, ems_a, emf_a, mb_a};
    assign o1 = {pc_we_b, ifs_b, iff_b, ies_b, ief_b, ems_b, emf_b, mb_b};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Drive inputs mid-cycle, let the Mealy outputs settle, compare both instances
    task automatic step(input string name, input in_t s, input logic [7:0] e3, input logic [7:0] e1);
        @(negedge clk);
        cur = s;
        #1;
        check({name, "/lat3"}, {24'd0, o3}, {24'd0, e3});
        check({name, "/lat1"}, {24'd0, o1}, {24'd0, e1});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cur = '0;
        cur.br = 1'b1;
        cur.mul_start = 1'b1;
        #1;
        check("reset/lat3", {24'd0, o3}, {24'd0, O_RST});
        check("reset/lat1", {24'd0, o1}, {24'd0, O_RST});
        @(negedge clk);
        rst = 1'b0;
        cur = '0;
    endtask

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic ms, input logic rd, input logic [4:0] wa,
                               input logic br, input logic rq, input logic rdy);
        in_t t;
        t = '{rs1, rs2, u1, u2, ms, rd, wa, br, rq, rdy};
        return t;
    endfunction

    vec_t vecs[11];
    in_t  idle, lu5, mul, memw;

    initial begin
        vecs[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_IDLE};
        vecs[1]  = '{mk(0, 5, 0, 1, 0, 1, 5, 0, 0, 0), O_LU};
        vecs[2]  = '{mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0), O_IDLE};
        vecs[3]  = '{mk(7, 3, 1, 0, 0, 1, 7, 0, 0, 0), O_LU};
        vecs[4]  = '{mk(7, 7, 0, 0, 0, 1, 7, 0, 0, 0), O_IDLE};
        vecs[5]  = '{mk(0, 5, 0, 1, 1, 1, 5, 1, 0, 0), O_BR};
        vecs[6]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_MEM};
        vecs[7]  = '{mk(0, 5, 0, 1, 1, 1, 5, 1, 1, 0), O_MEM};
        vecs[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), O_BR};
        vecs[9]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), O_IDLE};
        vecs[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_IDLE};

        idle = '0;
        lu5  = mk(0, 5, 0, 1, 0, 1, 5, 0, 0, 0);
        mul  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        memw = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Single-cycle decisions from RUN, reset between vectors
        for (int i = 0; i < 11; i++) begin
            do_reset();
            step($sformatf("vec%0d", i), vecs[i].stim, vecs[i].exp, vecs[i].exp);
        end

        // Load-use lasts one cycle once the bubble reaches EXE
        do_reset();
        step("lu_hit", lu5, O_LU, O_LU);
        step("lu_after", idle, O_IDLE, O_IDLE);

        // Multiply: busy for two cycles with MUL_LAT=3, never with MUL_LAT=1; branch ignored while busy
        do_reset();
        step("mul_start", mul, O_IDLE, O_IDLE);
        step("mul_n1_br", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_MUL, O_BR);
        step("mul_n2", idle, O_MUL, O_IDLE);
        step("mul_n3", idle, O_IDLE, O_IDLE);

        // Memory wait for four cycles, release ignores branch and load-use
        do_reset();
        step("memw0", memw, O_MEM, O_MEM);
        step("memw1", memw, O_MEM, O_MEM);
        step("memw2", memw, O_MEM, O_MEM);
        step("memw3", memw, O_MEM, O_MEM);
        step("mem_release", mk(0, 5, 0, 1, 0, 1, 5, 1, 1, 1), O_IDLE, O_IDLE);
        step("mem_run_br", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_BR, O_BR);

        // Multiply overlapping an unready DM access runs into MEM_WAIT
        do_reset();
        step("mm_start", mul, O_IDLE, O_IDLE);
        step("mm_n1", memw, O_MULMEM, O_MEM);
        step("mm_n2", memw, O_MULMEM, O_MEM);
        step("mm_wait", memw, O_MEM, O_MEM);
        step("mm_release", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), O_IDLE, O_IDLE);
        step("mm_run", idle, O_IDLE, O_IDLE);

        // Reset in the middle of a multiply
        do_reset();
        step("rm_start", mul, O_IDLE, O_IDLE);
        step("rm_busy", idle, O_MUL, O_IDLE);
        @(negedge clk);
        rst = 1'b1;
        cur = idle;
        #1;
        check("rm_rst/lat3", {24'd0, o3}, {24'd0, O_RST});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rm_after/lat3", {24'd0, o3}, {24'd0, O_IDLE});
        step("rm_after_br", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_BR, O_BR);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        do_reset();
        #1;
        check("perf_stall_rst", ps_a, 32'd0);
        check("perf_flush_rst", pf_a, 32'd0);
        step("perf_lu", lu5, O_LU, O_LU);
        step("perf_br", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_BR, O_BR);
        step("perf_idle", idle, O_IDLE, O_IDLE);
        check("perf_stall_cnt", ps_a, 32'd1);
        check("perf_flush_cnt", pf_a, 32'd1);
        check("perf_stall_cnt1", ps_b, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Generates the hold and bubble-insert controls for the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers.
- Resolves four conditions: load-use hazards, taken branches, multi-cycle multiply occupancy of EXE, and data-memory wait states.
- Single FSM plus a down-counter; all pipeline registers take their enables from this block.

Parameters:
REG_ADDR_W, 5, register-file address width
MUL_LAT, 3, total cycles a multiply occupies EXE (legal range 1..15)
CNT_W, 4, width of the multiply countdown counter (must hold MUL_LAT-1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
id_rs1_addr  in  REG_ADDR_W  source register 1 of the instruction in ID
id_rs2_addr  in  REG_ADDR_W  source register 2 of the instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
id_mul_start  in  1  ID instruction is a multiply
exe_DM_read  in  1  instruction in EXE is a load
exe_wr_addr  in  REG_ADDR_W  destination register of the EXE instruction
exe_branch_taken  in  1  branch resolved taken in EXE
dm_req  in  1  MEM stage is accessing data memory
dm_ready  in  1  data memory completes the access this cycle
pc_we  out  1  PC write enable
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  load NOP into IF/ID
id_exe_stall  out  1  hold ID/EXE
id_exe_flush  out  1  load NOP (reset values) into ID/EXE
exe_mem_stall  out  1  hold EXE/MEM
exe_mem_flush  out  1  load NOP into EXE/MEM
mul_busy  out  1  high while in MUL_BUSY

Behaviour:
- Reset: rst is sampled on clk and is synchronous, active-high. While rst=1 the outputs are pc_we=0 and all stall, flush and mul_busy signals are 0. The next state is RUN and the counter is cleared to 0.
- States: RUN, MUL_BUSY, MEM_WAIT. Outputs are decoded from the current state and current inputs (Mealy), so there is zero-cycle latency to the register enables.
- Default outputs in RUN with no event: pc_we=1, all others 0.
- Load-use hit (lu): exe_DM_read=1, exe_wr_addr!=0, and (id_rs1_used and id_rs1_addr==exe_wr_addr) or (id_rs2_used and id_rs2_addr==exe_wr_addr).
- RUN priority, highest first:
  1. dm_req and !dm_ready: pc_we=0, if_id_stall=1, id_exe_stall=1, exe_mem_stall=1. Next state MEM_WAIT. This condition masks branch, load-use and multiply-start decisions for this cycle.
  2. exe_branch_taken: if_id_flush=1, id_exe_flush=1, pc_we=1. Stay in RUN. Any lu or id_mul_start is ignored because the ID instruction is squashed.
  3. lu: pc_we=0, if_id_stall=1, id_exe_flush=1 (one bubble). Stay in RUN. The hazard clears on its own on the next cycle.
  4. id_mul_start: advance normally. If MUL_LAT>1, load the counter with MUL_LAT-1 and go to MUL_BUSY; otherwise stay in RUN.
- MUL_BUSY:
  - Outputs: pc_we=0, if_id_stall=1, id_exe_stall=1, exe_mem_flush=1, mul_busy=1.
  - The counter decrements every cycle.
  - If dm_req and !dm_ready: exe_mem_stall=1 and exe_mem_flush=0. The counter still decrements.
  - When counter==1: next state is RUN, or MEM_WAIT if memory is still not ready that cycle.
  - exe_branch_taken is ignored in this state, because EXE holds the multiply.
- MEM_WAIT:
  - While !dm_ready: freeze outputs as in RUN item 1.
  - In the cycle dm_ready=1: release with RUN default outputs (no branch/lu evaluation) and return to RUN.
- Counter: unsigned CNT_W bits, never decremented below 0. It is don't-care outside MUL_BUSY.
- Never assert stall and flush simultaneously on the same pipeline register. Flush wins if the priority logic would produce both.

Optional Feature:
PIPE_HAZARD_CTRL_PERF_EN
- Defined: adds two outputs, perf_stall_cyc[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cyc increments on every non-reset cycle with pc_we=0.
  - perf_flush_cnt increments on every cycle with if_id_flush=1.
  - Both saturate at 32'hFFFF_FFFF and clear to 0 on rst.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Load-use: exe_DM_read=1, exe_wr_addr=5, id_rs2_used=1, id_rs2_addr=5 -> pc_we=0, if_id_stall=1, id_exe_flush=1 for exactly 1 cycle, then pc_we=1. The same case with exe_wr_addr=0 -> no stall.
- Taken branch coincident with load-use hit -> if_id_flush=1, id_exe_flush=1, pc_we=1, no stall.
- Multiply with MUL_LAT=3: id_mul_start=1 in cycle N -> mul_busy=1 in N+1 and N+2, RUN in N+3. With MUL_LAT=1 -> mul_busy is never asserted.
- Memory wait: dm_req=1 with dm_ready low for 4 cycles -> all stalls high for 4 cycles, released in the cycle dm_ready=1, then RUN.
- Multiply overlapping memory wait: enter MUL_BUSY with dm_ready low through counter expiry -> transition to MEM_WAIT, with exe_mem_stall=1 and exe_mem_flush=0 throughout.
- Reset mid-MUL_BUSY: assert rst -> all outputs 0 that cycle, RUN next cycle. With PIPE_HAZARD_CTRL_PERF_EN: both counters read 0 after rst and saturate when preloaded near the maximum.
